// File: rtl/dot_product_stream.sv
// Purpose: streaming dot product; takes vector A then vector B on one element port and emits sum(A[i]*B[i]).
// Latency: the result is registered; out_valid rises the cycle after the last B element is accepted.
// Backpressure: in_ready drops while a result waits; out_ready=0 holds dout and out_valid; flush aborts the pair.
//
// Ports:
//   clk, resetn          clock and asynchronous active-low reset
//   in_valid/in_ready    element handshake on din (A elements first, then B elements)
//   din                  DATA_W-bit element, unsigned or two's complement per SIGNED
//   flush                synchronous abort of the pair in progress; wins over both handshakes
//   out_valid/out_ready  result handshake on dout
//   dout                 OUT_W-bit dot product; keeps the last result after it is consumed
module dot_product_stream #(
  parameter int DATA_W  = 8,
  parameter int VEC_LEN = 3,
  parameter int SIGNED  = 0,
  localparam int OUT_W  = 2*DATA_W + $clog2(VEC_LEN)
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] din,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  dout
);

  localparam int IDX_W = $clog2(VEC_LEN);
  localparam int PRD_W = 2*DATA_W;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(VEC_LEN - 1);

  typedef enum logic [1:0] {LOAD_A, LOAD_B, OUT} state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx;
  logic [OUT_W-1:0]   acc;
  logic [DATA_W-1:0]  a_mem [VEC_LEN];

  logic               xfer;
  logic               last;
  logic [DATA_W-1:0]  a_sel;
  logic [PRD_W-1:0]   prod_u;
  logic [PRD_W-1:0]   prod_s;
  logic [PRD_W-1:0]   prod;
  logic [OUT_W-1:0]   prod_ext;
  logic [OUT_W-1:0]   sum;

  // Only the state decides readiness, so in_ready never depends on in_valid.
  assign in_ready = (state_q != OUT);
  // A flush drops any element presented alongside it.
  assign xfer     = in_valid & in_ready & ~flush;
  assign last     = (idx == IDX_LAST);
  assign a_sel    = a_mem[idx];

  // Both operands are widened to the product width first, so the low PRD_W
  // bits of the product are exact for either interpretation.
  always_comb begin
    prod_u   = {{DATA_W{1'b0}}, a_sel} * {{DATA_W{1'b0}}, din};
    prod_s   = $signed({{DATA_W{a_sel[DATA_W-1]}}, a_sel}) *
               $signed({{DATA_W{din[DATA_W-1]}}, din});
    prod     = (SIGNED != 0) ? prod_s : prod_u;
    prod_ext = (SIGNED != 0) ? {{(OUT_W-PRD_W){prod[PRD_W-1]}}, prod}
                             : {{(OUT_W-PRD_W){1'b0}}, prod};
    sum      = acc + prod_ext;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = LOAD_A;
    end else begin
      case (state_q)
        LOAD_A:  if (xfer && last) state_d = LOAD_B;
        LOAD_B:  if (xfer && last) state_d = OUT;
        OUT:     if (out_ready)    state_d = LOAD_A;
        default: state_d = LOAD_A;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= LOAD_A;
      idx       <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
      for (int i = 0; i < VEC_LEN; i++) a_mem[i] <= '0;
    end else begin
      state_q <= state_d;
      if (flush) begin
        // dout deliberately keeps its value; stale A entries are rewritten before use.
        idx       <= '0;
        acc       <= '0;
        out_valid <= 1'b0;
      end else begin
        if (xfer) begin
          idx <= last ? '0 : idx + 1'b1;
          if (state_q == LOAD_A) begin
            a_mem[idx] <= din;
          end else begin
            acc <= sum;
            if (last) begin
              dout      <= sum;
              out_valid <= 1'b1;
            end
          end
        end
        if (state_q == OUT && out_ready) begin
          out_valid <= 1'b0;
          acc       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_dot_product_stream.sv
// Purpose: directed bench driving an unsigned and a signed instance with identical element streams.
// Latency: inputs change 1 time unit after a rising edge; outputs are sampled at that same offset.
// Backpressure: exercises out_ready stalls, input bubbles, flush and asynchronous reset.
module tb_dot_product_stream;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        flush;
  logic        out_ready;
  logic [7:0]  din;
  logic        u_in_ready, u_out_valid;
  logic [17:0] u_dout;
  logic        s_in_ready, s_out_valid;
  logic [17:0] s_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dot_product_stream #(.DATA_W(8), .VEC_LEN(3), .SIGNED(0)) dut_u (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(u_in_ready), .din(din),
    .flush(flush), .out_valid(u_out_valid), .out_ready(out_ready), .dout(u_dout)
  );

  dot_product_stream #(.DATA_W(8), .VEC_LEN(3), .SIGNED(1)) dut_s (
    .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(s_in_ready), .din(din),
    .flush(flush), .out_valid(s_out_valid), .out_ready(out_ready), .dout(s_dout)
  );

  typedef struct packed {
    logic [2:0][7:0] a;
    logic [2:0][7:0] b;
    logic [17:0]     exp_u;
    logic [17:0]     exp_s;
  } vec_t;

  vec_t tbl [7];

  function automatic vec_t mk(input logic [7:0] a0, a1, a2, b0, b1, b2,
                              input logic [17:0] eu, es);
    vec_t v;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2;
    v.exp_u = eu;
    v.exp_s = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one element for one cycle; both instances must be ready for it.
  task automatic send(input logic [7:0] d, input string tag);
    in_valid = 1'b1;
    din      = d;
    chk({tag, " u_in_ready"}, 32'(u_in_ready), 32'd1);
    chk({tag, " s_in_ready"}, 32'(s_in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    din      = 8'hEE;
  endtask

  // Back-to-back pair, result consumed on the first cycle it is valid.
  task automatic run_pair(input vec_t v, input string tag);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(v.a[i], $sformatf("%s A%0d", tag, i));
    for (int i = 0; i < 3; i++) send(v.b[i], $sformatf("%s B%0d", tag, i));
    chk({tag, " u_out_valid"}, 32'(u_out_valid), 32'd1);
    chk({tag, " s_out_valid"}, 32'(s_out_valid), 32'd1);
    chk({tag, " u_in_ready_out"}, 32'(u_in_ready), 32'd0);
    chk({tag, " u_dout"}, 32'(u_dout), 32'(v.exp_u));
    chk({tag, " s_dout"}, 32'(s_dout), 32'(v.exp_s));
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " u_out_valid_drop"}, 32'(u_out_valid), 32'd0);
    chk({tag, " s_out_valid_drop"}, 32'(s_out_valid), 32'd0);
    chk({tag, " u_in_ready_back"}, 32'(u_in_ready), 32'd1);
    chk({tag, " u_dout_kept"}, 32'(u_dout), 32'(v.exp_u));
  endtask

  initial begin
    tbl[0] = mk(8'd1,   8'd2,   8'd3,   8'd4,   8'd5,   8'd6,   18'd32,     18'd32);
    tbl[1] = mk(8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF,  8'hFF,  18'd195075, 18'd3);
    tbl[2] = mk(8'hFF,  8'd2,   8'hFD,  8'd4,   8'hFB,  8'd6,   18'd3040,   18'h3FFE0);
    tbl[3] = mk(8'h80,  8'h80,  8'h80,  8'h80,  8'h80,  8'h80,  18'd49152,  18'd49152);
    tbl[4] = mk(8'd127, 8'h80,  8'd0,   8'd127, 8'd127, 8'd5,   18'd32385,  18'h3FF81);
    tbl[5] = mk(8'h80,  8'd127, 8'd1,   8'd127, 8'h80,  8'hFF,  18'd32767,  18'h380FF);
    tbl[6] = mk(8'd2,   8'd2,   8'd2,   8'd3,   8'd3,   8'd3,   18'd18,     18'd18);

    resetn    = 1'b0;
    in_valid  = 1'b0;
    flush     = 1'b0;
    out_ready = 1'b0;
    din       = 8'h00;
    #1;
    chk("reset u_out_valid", 32'(u_out_valid), 32'd0);
    chk("reset s_out_valid", 32'(s_out_valid), 32'd0);
    chk("reset u_dout", 32'(u_dout), 32'd0);
    chk("reset s_dout", 32'(s_dout), 32'd0);
    repeat (2) tick();
    resetn = 1'b1;
    chk("post-reset u_in_ready", 32'(u_in_ready), 32'd1);
    chk("post-reset s_in_ready", 32'(s_in_ready), 32'd1);

    // Table of pairs, each back-to-back with immediate consumption.
    for (int r = 0; r < 7; r++) run_pair(tbl[r], $sformatf("row%0d", r));

    // Bubbles on the input, then the result is held for 5 cycles.
    begin
      logic [7:0] av [3];
      logic [7:0] bv [3];
      av = '{8'd1, 8'd2, 8'd3};
      bv = '{8'd4, 8'd5, 8'd6};
      for (int i = 0; i < 6; i++) begin
        int gap;
        gap = $urandom_range(0, 2);
        for (int g = 0; g < gap; g++) tick();
        send(i < 3 ? av[i] : bv[i-3], $sformatf("bubble e%0d", i));
      end
      chk("stall u_out_valid", 32'(u_out_valid), 32'd1);
      for (int c = 0; c < 5; c++) begin
        in_valid = 1'b1;
        din      = 8'h55;
        tick();
        chk($sformatf("stall%0d u_in_ready", c), 32'(u_in_ready), 32'd0);
        chk($sformatf("stall%0d u_out_valid", c), 32'(u_out_valid), 32'd1);
        chk($sformatf("stall%0d u_dout", c), 32'(u_dout), 32'd32);
        chk($sformatf("stall%0d s_dout", c), 32'(s_dout), 32'd32);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      chk("stall consumed u_out_valid", 32'(u_out_valid), 32'd0);
      chk("stall consumed s_out_valid", 32'(s_out_valid), 32'd0);
      // The 0x55 elements offered during the stall must not have been taken.
      run_pair(tbl[6], "after-stall");
    end

    // Flush after A complete and B[0] accepted; element in the flush cycle is dropped.
    send(8'd9, "flushA0");
    send(8'd9, "flushA1");
    send(8'd9, "flushA2");
    send(8'd9, "flushB0");
    flush    = 1'b1;
    in_valid = 1'b1;
    din      = 8'd7;
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush u_out_valid", 32'(u_out_valid), 32'd0);
    chk("flush u_in_ready", 32'(u_in_ready), 32'd1);
    chk("flush u_dout_kept", 32'(u_dout), 32'd18);
    run_pair(tbl[6], "after-flush");

    // Flush in OUT beats out_ready: result discarded, dout unchanged.
    for (int i = 0; i < 3; i++) send(tbl[0].a[i], $sformatf("outflush A%0d", i));
    for (int i = 0; i < 3; i++) send(tbl[0].b[i], $sformatf("outflush B%0d", i));
    chk("outflush u_out_valid", 32'(u_out_valid), 32'd1);
    flush     = 1'b1;
    out_ready = 1'b1;
    tick();
    flush     = 1'b0;
    out_ready = 1'b0;
    chk("outflush u_out_valid_drop", 32'(u_out_valid), 32'd0);
    chk("outflush u_in_ready", 32'(u_in_ready), 32'd1);
    chk("outflush u_dout", 32'(u_dout), 32'd32);
    run_pair(tbl[2], "after-outflush");

    // Asynchronous reset between edges in the middle of LOAD_B.
    for (int i = 0; i < 3; i++) send(8'd10, $sformatf("rst A%0d", i));
    send(8'd10, "rst B0");
    #2;
    resetn = 1'b0;
    #1;
    chk("async rst u_out_valid", 32'(u_out_valid), 32'd0);
    chk("async rst u_dout", 32'(u_dout), 32'd0);
    chk("async rst s_dout", 32'(s_dout), 32'd0);
    #2;
    resetn = 1'b1;
    tick();
    chk("after rst u_in_ready", 32'(u_in_ready), 32'd1);
    run_pair(tbl[0], "after-rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_product_stream.md
DOT_PRODUCT_STREAM -- requirements
Module: dot_product_stream

Interface
REQ-001 Parameter DATA_W, default 8: element width in bits; legal range 2..16.
REQ-002 Parameter VEC_LEN, default 3: elements per vector; legal range 2..64.
REQ-003 Parameter SIGNED, default 0: 0 treats elements as unsigned, 1 as two's complement.
REQ-004 Derived width OUT_W = 2*DATA_W + $clog2(VEC_LEN); not user-settable.
REQ-005 clk  input  1  single clock; all state updates on its rising edge.
REQ-006 resetn  input  1  asynchronous, active-low reset.
REQ-007 in_valid  input  1  din carries a valid element this cycle.
REQ-008 in_ready  output  1  block accepts an element this cycle.
REQ-009 din  input  DATA_W  element; vector A is all VEC_LEN elements first, then vector B.
REQ-010 flush  input  1  synchronous abort of the vector pair in progress.
REQ-011 out_valid  output  1  dout holds a new result not yet consumed.
REQ-012 out_ready  input  1  downstream consumes the result.
REQ-013 dout  output  OUT_W  dot product sum(A[i]*B[i]), sign-extended when SIGNED=1.

Function
REQ-014 An element transfers only in a cycle with in_valid=1 and in_ready=1; in_valid=0 cycles are bubbles with no state change.
REQ-015 States: LOAD_A, LOAD_B, OUT; index counter idx counts 0..VEC_LEN-1.
REQ-016 LOAD_A: in_ready=1; each transfer stores din into A[idx]; the transfer at idx=VEC_LEN-1 wraps idx to 0 and moves to LOAD_B.
REQ-017 LOAD_B: in_ready=1; each transfer does acc <= acc + A[idx]*din in the same edge, one element per cycle, no stall.
REQ-018 LOAD_B transfer at idx=VEC_LEN-1: dout <= final sum, out_valid <= 1, idx <= 0, state to OUT; out_valid rises the cycle after the last B element is accepted.
REQ-019 OUT: in_ready=0; out_valid=1; dout held stable while out_ready=0.
REQ-020 OUT with out_ready=1: out_valid <= 0, acc <= 0, state to LOAD_A; the next element is accepted no earlier than the following cycle.
REQ-021 Arithmetic: products are 2*DATA_W bits, signed or unsigned per SIGNED; the accumulator is OUT_W bits and never overflows for legal parameters; no saturation and no rounding.
REQ-022 dout keeps the last result after out_valid falls, until the next result is loaded.
REQ-023 flush=1 in any state: next cycle state=LOAD_A, idx=0, acc=0, out_valid=0; dout is unchanged; any element presented in the flush cycle is dropped.
REQ-024 flush takes priority over in and out handshakes in the same cycle; a result in OUT is discarded even if out_ready=1.
REQ-025 Partial A contents remain in storage after a flush but are overwritten before use.

Reset
REQ-026 While resetn=0, asynchronously: state=LOAD_A, idx=0, acc=0, out_valid=0, dout=0, A storage=0.
REQ-027 in_ready=1 in the first cycle after resetn deasserts.
REQ-028 Reset asserted mid-vector or in OUT discards all progress and any pending result.

Verification
REQ-029 Defaults, A=[1,2,3], B=[4,5,6] back-to-back, out_ready=1 -> out_valid pulses for 1 cycle, the cycle after B[2] is accepted, dout=32, in_ready=0 only in that cycle.
REQ-030 Defaults, all elements 255 -> dout=195075 (full-scale, no overflow in 18 bits).
REQ-031 SIGNED=1: A=[-1,2,-3], B=[4,-5,6] -> dout=-32 (18'h3FFE0); A=B=[-128,-128,-128] -> dout=49152.
REQ-032 Random in_valid bubbles plus out_ready held 0 for 5 cycles in OUT -> in_ready=0 and dout stable throughout; the result is consumed on the first out_ready=1 cycle.
REQ-033 flush after A complete and B[0] accepted, then new pair [2,2,2]·[3,3,3] -> dout=18 with no contribution from the aborted pair.
REQ-034 resetn pulsed low mid-LOAD_B (asynchronous, between edges) -> out_valid=0 and dout=0 immediately; the next full pair computes correctly.
